// File: rtl/div_clk_monitor.sv
// div_clk_monitor
// Checks a divided clock (clki) by sampling it as data in the clk domain.
// Each rise-to-rise window gives one period and one high-time measurement.
// The monitor locks after LOCK_N in-tolerance periods in a row. It pulses err
// on an out-of-tolerance period, or when clki stays stuck long enough that the
// period counter saturates.
module div_clk_monitor #(
  parameter int CNT_W       = 8,
  parameter int EXP_PERIOD  = 3,
  parameter int TOL         = 0,
  parameter int LOCK_N      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clki,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_vld,
  output logic             locked,
  output logic             err
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);

  // The tolerance window is one bit wider than the counter, so EXP_PERIOD+TOL
  // cannot wrap. A negative lower bound clamps to zero.
  localparam logic [CNT_W:0] LO_BOUND =
    (EXP_PERIOD > TOL) ? (CNT_W+1)'(EXP_PERIOD - TOL) : '0;
  localparam logic [CNT_W:0] HI_BOUND = (CNT_W+1)'(EXP_PERIOD + TOL);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_N);

  localparam logic [1:0] SEEK = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   s_d_reg;
  logic                   s;
  logic                   rise;
  logic                   fall;

  logic [1:0]        state_reg,     state_next;
  logic [CNT_W-1:0]  per_cnt_reg,   per_cnt_next;
  logic [CNT_W-1:0]  hi_cnt_reg,    hi_cnt_next;
  logic [GOOD_W-1:0] good_cnt_reg,  good_cnt_next;
  logic [CNT_W-1:0]  period_reg,    period_next;
  logic [CNT_W-1:0]  high_reg,      high_next;
  logic              meas_vld_reg,  meas_vld_next;
  logic              locked_reg,    locked_next;
  logic              err_reg,       err_next;
  logic              in_tol;

  // Synchronizer shift path: stage 0 takes clki, and each later stage takes the
  // stage before it.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = clki;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign s    = sync_reg[SYNC_STAGES-1];
  assign rise = s & ~s_d_reg;
  assign fall = ~s & s_d_reg;

  assign in_tol = ({1'b0, per_cnt_reg} >= LO_BOUND) &&
                  ({1'b0, per_cnt_reg} <= HI_BOUND);

  // Measurement FSM. The rise that closes one window also opens the next one.
  always_comb begin
    state_next    = state_reg;
    per_cnt_next  = per_cnt_reg;
    hi_cnt_next   = hi_cnt_reg;
    good_cnt_next = good_cnt_reg;
    period_next   = period_reg;
    high_next     = high_reg;
    locked_next   = locked_reg;
    meas_vld_next = 1'b0;
    err_next      = 1'b0;

    if (!en) begin
      state_next    = SEEK;
      per_cnt_next  = '0;
      hi_cnt_next   = '0;
      good_cnt_next = '0;
      locked_next   = 1'b0;
    end else begin
      case (state_reg)
        SEEK: begin
          per_cnt_next = '0;
          hi_cnt_next  = '0;
          if (rise) begin
            per_cnt_next = CNT_ONE;
            hi_cnt_next  = CNT_ONE;
            state_next   = HIGH;
          end
        end

        HIGH: begin
          if (per_cnt_reg == CNT_MAX) begin
            err_next      = 1'b1;
            locked_next   = 1'b0;
            good_cnt_next = '0;
            per_cnt_next  = '0;
            hi_cnt_next   = '0;
            state_next    = SEEK;
          end else if (fall) begin
            per_cnt_next = per_cnt_reg + CNT_ONE;
            state_next   = LOW;
          end else begin
            per_cnt_next = per_cnt_reg + CNT_ONE;
            hi_cnt_next  = hi_cnt_reg + CNT_ONE;
          end
        end

        LOW: begin
          // A rise beats saturation, so a 2^CNT_W-1 period is still measured.
          if (rise) begin
            period_next   = per_cnt_reg;
            high_next     = hi_cnt_reg;
            meas_vld_next = 1'b1;
            if (in_tol) begin
              if (good_cnt_reg != GOOD_MAX) begin
                good_cnt_next = good_cnt_reg + 1'b1;
              end
              locked_next = (good_cnt_next == GOOD_MAX);
            end else begin
              good_cnt_next = '0;
              locked_next   = 1'b0;
              err_next      = 1'b1;
            end
            per_cnt_next = CNT_ONE;
            hi_cnt_next  = CNT_ONE;
            state_next   = HIGH;
          end else if (per_cnt_reg == CNT_MAX) begin
            err_next      = 1'b1;
            locked_next   = 1'b0;
            good_cnt_next = '0;
            per_cnt_next  = '0;
            hi_cnt_next   = '0;
            state_next    = SEEK;
          end else begin
            per_cnt_next = per_cnt_reg + CNT_ONE;
          end
        end

        default: begin
          state_next   = SEEK;
          per_cnt_next = '0;
          hi_cnt_next  = '0;
        end
      endcase
    end
  end

  // State, counters, synchronizer and registered outputs; async active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg     <= '0;
      s_d_reg      <= 1'b0;
      state_reg    <= SEEK;
      per_cnt_reg  <= '0;
      hi_cnt_reg   <= '0;
      good_cnt_reg <= '0;
      period_reg   <= '0;
      high_reg     <= '0;
      meas_vld_reg <= 1'b0;
      locked_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      sync_reg     <= sync_next;
      s_d_reg      <= s;
      state_reg    <= state_next;
      per_cnt_reg  <= per_cnt_next;
      hi_cnt_reg   <= hi_cnt_next;
      good_cnt_reg <= good_cnt_next;
      period_reg   <= period_next;
      high_reg     <= high_next;
      meas_vld_reg <= meas_vld_next;
      locked_reg   <= locked_next;
      err_reg      <= err_next;
    end
  end

  assign period    = period_reg;
  assign high_time = high_reg;
  assign meas_vld  = meas_vld_reg;
  assign locked    = locked_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor. Two instances share one stimulus: instance 0 uses
// the defaults (TOL=0) and instance 1 uses TOL=1. A timestamp-based model
// predicts every output on every cycle. Directed segments add literal
// expectations.
module tb_div_clk_monitor;

  localparam int SS    = 2;
  localparam int CW    = 8;
  localparam int EXP   = 3;
  localparam int LOCKN = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic en   = 1'b0;
  logic clki = 1'b0;

  logic [CW-1:0] per_o [2];
  logic [CW-1:0] hi_o  [2];
  logic          mv_o  [2];
  logic          lk_o  [2];
  logic          er_o  [2];

  always #5 clk = ~clk;

  div_clk_monitor #(.CNT_W(CW), .EXP_PERIOD(EXP), .TOL(0), .LOCK_N(LOCKN), .SYNC_STAGES(SS)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clki(clki),
    .period(per_o[0]), .high_time(hi_o[0]), .meas_vld(mv_o[0]), .locked(lk_o[0]), .err(er_o[0])
  );

  div_clk_monitor #(.CNT_W(CW), .EXP_PERIOD(EXP), .TOL(1), .LOCK_N(LOCKN), .SYNC_STAGES(SS)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clki(clki),
    .period(per_o[1]), .high_time(hi_o[1]), .meas_vld(mv_o[1]), .locked(lk_o[1]), .err(er_o[1])
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each window is described by timestamps: the cycle of its opening rise (t0)
  // and the cycle of its fall (tf). Period = next rise - t0. High = tf - t0.
  int  tolv [2] = '{0, 1};
  bit  hist [0:SS];
  int  cyc;
  bit  win  [2];
  int  t0   [2];
  int  tf   [2];
  int  grun [2];
  int  d;
  bit  m_s, m_sd, m_rise, m_fall;
  logic [CW-1:0] e_per [2];
  logic [CW-1:0] e_hi  [2];
  bit  e_mv [2];
  bit  e_lk [2];
  bit  e_err[2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k <= SS; k++) hist[k] = 1'b0;
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
        win[i] = 1'b0; t0[i] = 0; tf[i] = -1; grun[i] = 0;
        e_per[i] = '0; e_hi[i] = '0; e_mv[i] = 1'b0; e_lk[i] = 1'b0; e_err[i] = 1'b0;
      end
    end else begin
      m_s    = hist[SS-1];
      m_sd   = hist[SS];
      m_rise = m_s && !m_sd;
      m_fall = !m_s && m_sd;
      for (int i = 0; i < 2; i++) begin
        e_mv[i]  = 1'b0;
        e_err[i] = 1'b0;
        if (!en) begin
          win[i] = 1'b0; grun[i] = 0; e_lk[i] = 1'b0;
        end else if (!win[i]) begin
          if (m_rise) begin win[i] = 1'b1; t0[i] = cyc; tf[i] = -1; end
        end else begin
          d = cyc - t0[i];
          if (m_rise) begin
            e_per[i] = CW'(d);
            e_hi[i]  = CW'(tf[i] - t0[i]);
            e_mv[i]  = 1'b1;
            if (d >= EXP - tolv[i] && d <= EXP + tolv[i]) begin
              if (grun[i] < LOCKN) grun[i]++;
              e_lk[i] = (grun[i] >= LOCKN);
            end else begin
              grun[i] = 0; e_lk[i] = 1'b0; e_err[i] = 1'b1;
            end
            t0[i] = cyc; tf[i] = -1;
          end else if (d == MAXC) begin
            e_err[i] = 1'b1; e_lk[i] = 1'b0; grun[i] = 0; win[i] = 1'b0;
          end else if (m_fall && tf[i] < 0) begin
            tf[i] = cyc;
          end
        end
      end
      for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = clki;
      cyc++;
    end
  end

  // ---------------- per-cycle compare and event counters ----------------
  int mvc     [2];
  int erc     [2];
  int lock_at [2];
  bit lkp     [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("period",    i, int'(per_o[i]), int'(e_per[i]));
      chk("high_time", i, int'(hi_o[i]),  int'(e_hi[i]));
      chk("meas_vld",  i, int'(mv_o[i]),  int'(e_mv[i]));
      chk("locked",    i, int'(lk_o[i]),  int'(e_lk[i]));
      chk("err",       i, int'(er_o[i]),  int'(e_err[i]));
      if (mv_o[i]) mvc[i]++;
      if (er_o[i]) erc[i]++;
      if (lk_o[i] && !lkp[i]) lock_at[i] = mvc[i];
      lkp[i] = lk_o[i];
    end
    if (mv_o[0] || er_o[0])
      $display("t=%0t inst0 meas_vld=%0d period=%0d high=%0d locked=%0d err=%0d",
               $time, mv_o[0], per_o[0], hi_o[0], lk_o[0], er_o[0]);
  end

  // ---------------- stimulus ----------------
  task automatic mark();
    for (int i = 0; i < 2; i++) begin mvc[i] = 0; erc[i] = 0; lock_at[i] = 0; end
  endtask

  task automatic drive_per(input int p, input int h, input int n);
    for (int r = 0; r < n; r++) begin
      for (int k = 0; k < p; k++) begin
        clki = (k < h);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic hold(input logic v, input int n);
    clki = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int snap;
  int p, h;

  initial begin
    for (int i = 0; i < 2; i++) begin mvc[i] = 0; erc[i] = 0; lock_at[i] = 0; lkp[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_period", 0, int'(per_o[0]), 0);
    chk("reset_high",   0, int'(hi_o[0]),  0);
    chk("reset_locked", 0, int'(lk_o[0]),  0);
    chk("reset_mv",     0, int'(mv_o[0]),  0);
    chk("reset_err",    0, int'(er_o[0]),  0);
    rst = 1'b1;
    hold(1'b0, 2);

    // 1: steady /3; the first rise only opens a window.
    mark(); en = 1'b1;
    drive_per(3, 2, 10); hold(1'b0, 4);
    chk("t1_model_period", 0, int'(e_per[0]), 3);
    chk("t1_lock_at", 0, lock_at[0], 4);
    chk("t1_lock_at", 1, lock_at[1], 4);
    chk("t1_mv_count", 0, mvc[0], 9);
    chk("t1_err_count", 0, erc[0], 0);
    chk("t1_period", 0, int'(per_o[0]), 3);
    chk("t1_high", 0, int'(hi_o[0]), 2);
    chk("t1_locked", 0, int'(lk_o[0]), 1);

    // 2: switch to /5, then back to /3.
    mark();
    drive_per(5, 2, 3); drive_per(3, 2, 1); hold(1'b0, 4);
    chk("t2_err_count", 0, erc[0], 4);
    chk("t2_mv_count", 0, mvc[0], 4);
    chk("t2_period", 0, int'(per_o[0]), 5);
    chk("t2_locked", 0, int'(lk_o[0]), 0);
    mark();
    drive_per(3, 2, 8); hold(1'b0, 4);
    chk("t2_relock_at", 0, lock_at[0], 5);
    chk("t2_relock_err", 0, erc[0], 1);
    chk("t2_relocked", 0, int'(lk_o[0]), 1);

    // 3a: clki stuck high while locked.
    mark();
    drive_per(3, 2, 6); hold(1'b1, 20);
    chk("t3_locked_before", 0, int'(lk_o[0]), 1);
    snap = mvc[0];
    chk("t3_mv_before", 0, snap, 7);
    hold(1'b1, 280);
    chk("t3_no_mv_stuck", 0, mvc[0], snap);
    chk("t3_err_count", 0, erc[0], 2);
    chk("t3_locked_after", 0, int'(lk_o[0]), 0);
    chk("t3_period_hold", 0, int'(per_o[0]), 3);
    chk("t3_high_hold", 0, int'(hi_o[0]), 2);

    // 3b: clki stuck low while locked.
    mark();
    drive_per(3, 2, 6); hold(1'b0, 20);
    chk("t3b_lock_at", 0, lock_at[0], 4);
    chk("t3b_locked_before", 0, int'(lk_o[0]), 1);
    hold(1'b0, 280);
    chk("t3b_mv_count", 0, mvc[0], 4);
    chk("t3b_err_count", 0, erc[0], 1);
    chk("t3b_locked_after", 0, int'(lk_o[0]), 0);
    chk("t3b_period_hold", 0, int'(per_o[0]), 3);

    // 4: periods 2/3/4 accepted with TOL=1, then a 5 is rejected.
    mark();
    for (int r = 0; r < 3; r++) begin
      drive_per(2, 1, 1); drive_per(3, 1, 1); drive_per(4, 1, 1);
    end
    drive_per(5, 2, 1); drive_per(3, 1, 1); hold(1'b0, 4);
    chk("t4_lock_at", 1, lock_at[1], 4);
    chk("t4_err_count", 1, erc[1], 1);
    chk("t4_mv_count", 1, mvc[1], 10);
    chk("t4_locked", 1, int'(lk_o[1]), 0);
    chk("t4_period", 1, int'(per_o[1]), 5);

    // 5: drop en mid-lock, then raise it again.
    drive_per(3, 1, 8);
    chk("t5_locked_before", 0, int'(lk_o[0]), 1);
    en = 1'b0;
    drive_per(3, 1, 1);
    chk("t5_unlock", 0, int'(lk_o[0]), 0);
    mark();
    drive_per(3, 1, 3);
    chk("t5_no_mv", 0, mvc[0], 0);
    chk("t5_no_err", 0, erc[0], 0);
    en = 1'b1; mark();
    drive_per(3, 1, 8); hold(1'b0, 4);
    chk("t5_lock_at", 0, lock_at[0], 4);
    chk("t5_mv_count", 0, mvc[0], 7);
    chk("t5_err_count", 0, erc[0], 0);

    // 6: async reset while the FSM is in HIGH.
    drive_per(3, 2, 6);
    chk("t6_locked_before", 0, int'(lk_o[0]), 1);
    hold(1'b1, 4);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_period", 0, int'(per_o[0]), 0);
    chk("t6_rst_high",   0, int'(hi_o[0]),  0);
    chk("t6_rst_locked", 0, int'(lk_o[0]),  0);
    chk("t6_rst_mv",     0, int'(mv_o[0]),  0);
    chk("t6_rst_err",    0, int'(er_o[0]),  0);
    @(posedge clk); #1;
    rst = 1'b1; mark();
    drive_per(3, 2, 8); hold(1'b0, 4);
    chk("t6_lock_at", 0, lock_at[0], 4);
    chk("t6_mv_count", 0, mvc[0], 7);
    chk("t6_err_count", 0, erc[0], 0);

    // 7: a 255-cycle period is still measured; a 256-cycle one saturates first.
    mark();
    drive_per(3, 1, 2); drive_per(255, 1, 1); drive_per(3, 1, 1); hold(1'b0, 4);
    chk("t7_period_max", 0, int'(per_o[0]), 255);
    chk("t7_period_max", 1, int'(per_o[1]), 255);
    chk("t7_high_max", 0, int'(hi_o[0]), 1);
    chk("t7_err_seen", 0, (erc[0] > 0) ? 1 : 0, 1);
    mark();
    drive_per(3, 1, 1); drive_per(256, 1, 1); drive_per(3, 1, 1); hold(1'b0, 4);
    chk("t7_sat_mv", 0, mvc[0], 2);
    chk("t7_sat_err", 0, erc[0], 2);
    chk("t7_sat_period", 0, int'(per_o[0]), 3);

    // Random periods, duty cycles, en drops and long holds near saturation.
    for (int n = 0; n < 150; n++) begin
      en = ($urandom_range(0, 11) != 0);
      if ($urandom_range(0, 39) == 0) begin
        hold(1'($urandom_range(0, 1)), $urandom_range(250, 262));
      end else begin
        p = $urandom_range(2, 9);
        h = $urandom_range(1, p - 1);
        drive_per(p, h, 1);
      end
    end
    en = 1'b1;
    hold(1'b0, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
